// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, bubble encoding and the
// instruction-fetch state enum used by the fetch stage, hazard unit and benches.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the PC, runs one req/ack access at a time to
// instruction memory, honours stall (hold) and redirect (flush + refetch), and
// every cycle presents PC+4 and an instruction or a NOP bubble to IF/ID.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   stall             hold the presented instruction, do not advance
//   redirect_valid/pc taken branch/jump; target bits [1:0] ignored
//   imem_req/addr     fetch request, address stable while req is high
//   imem_ack/rdata    one-cycle completion pulse with the instruction word
//   PC_out            pc+4 of the presented instruction
//   instruction_out   presented instruction (NOP_INSTR when a bubble)
//   inst_valid        1 when instruction_out is a real instruction
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        inst_valid
);

  localparam int unsigned AW = 32;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] r_hold;
  logic [AW-1:0] w_hold_nxt;
  logic [AW-1:0] r_drop_addr;
  logic [AW-1:0] w_drop_nxt;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_target;
  logic          w_unused_ok;

  assign w_pc_inc    = AW'(r_pc + 32'd4);
  assign w_target    = {redirect_pc[31:2], 2'b00};
  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  // State, PC, hold and drop-address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_hold      <= NOP_INSTR;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_hold      <= w_hold_nxt;
      r_drop_addr <= w_drop_nxt;
    end
  end

  // Next-state, next-PC mux and presented outputs; redirect > stall > advance
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_hold_nxt      = r_hold;
    w_drop_nxt      = r_drop_addr;
    imem_req        = 1'b0;
    imem_addr       = r_pc;
    PC_out          = w_pc_inc;
    instruction_out = NOP_INSTR;
    inst_valid      = 1'b0;

    case (r_state)
      BOOT: begin
        if (redirect_valid) w_pc_nxt = w_target;
        w_state_nxt = REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          w_pc_nxt = w_target;
          // Access still in flight: remember its address so it completes cleanly
          if (!imem_ack) begin
            w_drop_nxt  = r_pc;
            w_state_nxt = DROP;
          end
        end else if (imem_ack) begin
          instruction_out = imem_rdata;
          inst_valid      = 1'b1;
          if (stall) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = HOLD;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_target;
          w_state_nxt = REQ;
        end else begin
          instruction_out = r_hold;
          inst_valid      = 1'b1;
          if (!stall) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = REQ;
          end
        end
      end

      DROP: begin
        // Keep the killed address on the bus until memory acknowledges it
        imem_req  = 1'b1;
        imem_addr = r_drop_addr;
        if (redirect_valid) w_pc_nxt = w_target;
        if (imem_ack) w_state_nxt = REQ;
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the PC, issues one instruction-memory request at a time over a req/ack handshake, and honours stall from the hazard unit and redirect from branch/jump resolution. Each cycle it presents PC+4 and an instruction (or a NOP bubble) for IF/ID to latch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold the current instruction, do not advance
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  redirect target; bits [1:0] ignored
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  word-aligned fetch address; stable while imem_req high
imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle; may arrive in the same cycle as req (zero-wait)
imem_rdata  input  32  instruction word
PC_out  output  32  pc+4 of the presented instruction, to IF/ID PC_in
instruction_out  output  32  presented instruction, to IF/ID instruction_in
inst_valid  output  1  1 = real instruction; 0 = instruction_out is NOP_INSTR

Behaviour:
- Clock clk; reset is asynchronous and active-low on rst_n. Assertion forces state BOOT, pc=RESET_PC, and hold register=NOP_INSTR immediately.
- While in BOOT, outputs are imem_req=0, inst_valid=0, instruction_out=NOP_INSTR, and PC_out=RESET_PC+4.
- A reset mid-request abandons the outstanding access; the memory is reset alongside this stage.
- State BOOT: one cycle after reset release, then REQ.
- State REQ: imem_req=1 and imem_addr=pc.
  - ack & !redirect & !stall: present imem_rdata with inst_valid=1 combinationally; pc<=pc+4; stay in REQ. This gives a zero-wait throughput of 1 instruction/cycle.
  - ack & !redirect & stall: present imem_rdata and capture it in the hold register; go to HOLD; pc unchanged.
  - !ack & !redirect: present a NOP bubble (inst_valid=0); stay in REQ.
  - redirect & ack: discard the data; pc<={redirect_pc[31:2],2'b00}; stay in REQ.
  - redirect & !ack: pc<=target; go to DROP.
- State HOLD: imem_req=0; present the hold register with inst_valid=1.
  - !stall: pc<=pc+4; go to REQ.
  - redirect: discard; pc<=target; go to REQ.
- State DROP: imem_req=1 and imem_addr=the killed address, which stays stable until the protocol completes; output a bubble.
  - ack: discard the data; go to REQ, which fetches pc.
  - Another redirect while in DROP overwrites pc; the last redirect wins.
- Priority: redirect > stall > advance. Whenever redirect_valid=1, inst_valid=0 and instruction_out=NOP_INSTR in that same cycle.
- The stage never has more than one outstanding request.
- PC_out is always pc+4 of the address being presented; in HOLD this is the held instruction's address.
- Arithmetic is 32-bit modulo: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
- Stall while outputting a bubble has no effect beyond staying in the current state.
- An imem_ack outside REQ/DROP is a protocol error and is ignored.
- Registered state: pc, the state register, hold register, and a separate drop_addr register used in DROP. imem_addr = (state==DROP) ? drop_addr : pc.

Decomposition:
- Shared package mips_pkg: NOP_INSTR, RESET_PC default, and the fetch-state enum (BOOT, REQ, HOLD, DROP) so the hazard unit and testbench can reference them.
- No sub-module is required. The next-PC mux (pc+4 / redirect / hold) stays inline in one always block alongside the state register.

Test Plan:
- Reset release, zero-wait memory returning addr-based data: imem_addr sequence is 0x0,0x4,0x8. PC_out is 0x4,0x8,0xC. inst_valid=1 every cycle after BOOT.
- Memory with 2-cycle ack latency: one bubble per fetch (inst_valid=0, instruction_out=0). imem_addr stays 0x0 until ack, then becomes 0x4.
- Stall asserted the cycle of ack for instr 0x8C010004 at pc 0x10, held 3 cycles: instruction_out=0x8C010004 and PC_out=0x14 for 4 cycles with imem_req=0. Next addr is 0x14.
- Redirect to 0x40 while the request for 0x20 awaits ack (latency 3): DROP keeps imem_addr=0x20 until ack. Data is discarded with no inst_valid. The next request is to 0x40; PC_out=0x44.
- Redirect and stall together in HOLD, target 0x103: redirect wins, target is aligned to 0x100, and the held instruction is never presented after that cycle.
- Wrap and async reset: RESET_PC=0xFFFFFFFC gives addresses 0xFFFFFFFC then 0x0. Asserting rst_n low mid-REQ drops imem_req immediately with no clock edge.
